invader_grid_ctl: RTL

INVADER_GRID_CTL -- requirements
Module: invader_grid_ctl

---
 rtl/invader_pkg.sv | 22 ++
 rtl/vga_pkg.sv | 8 +
 rtl/invader_box_overlap.sv | 29 ++
 rtl/invader_grid_ctl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/invader_pkg.sv
// invader_pkg
//   Collision FSM state type and the per-row score table for the invader
//   formation controller.
//   Ports: none (package).
package invader_pkg;
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_SCAN       = 2'd1,
      ST_HIT        = 2'd2,
      ST_WAIT_CLEAR = 2'd3
   } inv_state_t;

   localparam logic [15:0] SCORE_ROW_TOP = 16'd30;  // row 0
   localparam logic [15:0] SCORE_ROW_MID = 16'd20;  // rows 1 and 2
   localparam logic [15:0] SCORE_ROW_LOW = 16'd10;  // remaining rows

   function automatic logic [15:0] row_points(input int row);
      if (row == 0)      return SCORE_ROW_TOP;
      else if (row <= 2) return SCORE_ROW_MID;
      else               return SCORE_ROW_LOW;
   endfunction
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg
//   Display geometry shared by the video blocks. The invader formation uses
//   HOR_PIXELS as its right-hand turn-around limit.
//   Ports: none (package).
package vga_pkg;
   localparam int HOR_PIXELS = 1024;
   localparam int VER_PIXELS = 768;
endpackage

// File: rtl/invader_box_overlap.sv
// invader_box_overlap
//   Combinational strict-overlap test between the player bullet box and one
//   invader box. Sums are carried in 13 bits so nothing wraps.
//   Ports:
//     bx, by  : bullet top-left corner (12 bit)
//     x0, y0  : invader top-left corner (13 bit)
//     hit     : boxes overlap (touching edges do not count)
module invader_box_overlap #(
   parameter int INV_W    = 32,
   parameter int INV_H    = 32,
   parameter int BULLET_W = 32,
   parameter int BULLET_H = 32
) (
   input  logic [11:0] bx,
   input  logic [11:0] by,
   input  logic [12:0] x0,
   input  logic [12:0] y0,
   output logic        hit
);
   logic [12:0] bx13, by13;

   assign bx13 = {1'b0, bx};
   assign by13 = {1'b0, by};

   assign hit = (bx13 < x0 + 13'(INV_W))     &&
                (bx13 + 13'(BULLET_W) > x0)  &&
                (by13 < y0 + 13'(INV_H))     &&
                (by13 + 13'(BULLET_H) > y0);
endmodule

// File: rtl/invader_grid_ctl.sv
// invader_grid_ctl
//   Space-invader formation controller: marches the formation left/right with
//   edge drops on a fixed tick, and resolves player-bullet collisions by
//   scanning one invader per clock against a snapshot of bullet and grid.
//   Optional feature macro: INVADER_SCORE_EN (row-weighted score counter;
//   when undefined, score is tied to zero).
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     bullet_active/x/y     : player bullet state and top-left corner
//     bullet_hit            : one-cycle pulse when an invader is destroyed
//     grid_x, grid_y        : formation top-left corner
//     alive                 : one bit per invader, index = row*COLS+col
//     hit_idx               : index of the last invader destroyed
//     all_dead, reached_bottom : sticky end-of-wave flags (freeze movement)
//     score                 : accumulated points
module invader_grid_ctl
   import invader_pkg::*;
   import vga_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 8,
   parameter int INV_W      = 32,
   parameter int INV_H      = 32,
   parameter int GAP        = 16,
   parameter int BULLET_W   = 32,
   parameter int BULLET_H   = 32,
   parameter int STEP_X     = 4,
   parameter int STEP_Y     = 16,
   parameter int MOVE_DELAY = 650000,
   parameter int ORIGIN_X   = 64,
   parameter int ORIGIN_Y   = 64,
   parameter int BOTTOM_Y   = 704,
   localparam int N         = ROWS * COLS,
   localparam int IDX_W     = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bullet_active,
   input  logic [11:0]      bullet_x,
   input  logic [11:0]      bullet_y,
   output logic             bullet_hit,
   output logic [11:0]      grid_x,
   output logic [11:0]      grid_y,
   output logic [N-1:0]     alive,
   output logic [IDX_W-1:0] hit_idx,
   output logic             all_dead,
   output logic             reached_bottom,
   output logic [15:0]      score
);
   localparam int PITCH_X = INV_W + GAP;
   localparam int PITCH_Y = INV_H + GAP;
   localparam int GRID_W  = COLS * PITCH_X - GAP;
   localparam int GRID_H  = ROWS * PITCH_Y - GAP;
   localparam int CNT_W   = (MOVE_DELAY > 0) ? $clog2(MOVE_DELAY + 1) : 1;

   // ---------------- movement ----------------
   logic [CNT_W-1:0] tick_cnt;
   logic             tick, dir_left, frozen;
   logic             at_right, at_left, at_bottom;

   assign tick      = (tick_cnt == CNT_W'(MOVE_DELAY));
   assign frozen    = all_dead | reached_bottom;
   assign at_right  = ({1'b0, grid_x} + 13'(GRID_W + STEP_X)) > 13'(HOR_PIXELS);
   assign at_left   = grid_x < 12'(STEP_X);
   assign at_bottom = ({1'b0, grid_y} + 13'(GRID_H)) >= 13'(BOTTOM_Y);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt       <= '0;
         grid_x         <= 12'(ORIGIN_X);
         grid_y         <= 12'(ORIGIN_Y);
         dir_left       <= 1'b0;
         all_dead       <= 1'b0;
         reached_bottom <= 1'b0;
      end else begin
         tick_cnt       <= tick ? '0 : tick_cnt + 1'b1;
         all_dead       <= all_dead | ~|alive;
         reached_bottom <= reached_bottom | at_bottom;
         if (tick && !frozen) begin
            if (!dir_left) begin
               if (at_right) begin
                  grid_y   <= grid_y + 12'(STEP_Y);
                  dir_left <= 1'b1;
               end else begin
                  grid_x <= grid_x + 12'(STEP_X);
               end
            end else begin
               if (at_left) begin
                  grid_y   <= grid_y + 12'(STEP_Y);
                  dir_left <= 1'b0;
               end else begin
                  grid_x <= grid_x - 12'(STEP_X);
               end
            end
         end
      end
   end

   // ---------------- collision scan ----------------
   inv_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [11:0]      snap_bx, snap_by, snap_gx, snap_gy;
   logic [12:0]      box_x0, box_y0;
   logic             box_hit;

   // Scan works entirely on the snapshot, so grid ticks and bullet drops
   // during SCAN cannot disturb it.
   always_comb begin
      box_x0 = {1'b0, snap_gx} + 13'((int'(idx) % COLS) * PITCH_X);
      box_y0 = {1'b0, snap_gy} + 13'((int'(idx) / COLS) * PITCH_Y);
   end

   invader_box_overlap #(
      .INV_W   (INV_W),
      .INV_H   (INV_H),
      .BULLET_W(BULLET_W),
      .BULLET_H(BULLET_H)
   ) u_overlap (
      .bx (snap_bx),
      .by (snap_by),
      .x0 (box_x0),
      .y0 (box_y0),
      .hit(box_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         hit_idx <= '0;
         alive   <= '1;
         snap_bx <= '0;
         snap_by <= '0;
         snap_gx <= '0;
         snap_gy <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bullet_active) begin
                  snap_bx <= bullet_x;
                  snap_by <= bullet_y;
                  snap_gx <= grid_x;
                  snap_gy <= grid_y;
                  idx     <= '0;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (alive[idx] && box_hit) begin
                  hit_idx <= idx;
                  state   <= ST_HIT;
               end else if (idx == IDX_W'(N - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_HIT: begin
               alive[hit_idx] <= 1'b0;
               state          <= ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
               // One kill per bullet: wait for the player to retire it.
               if (!bullet_active) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bullet_hit = (state == ST_HIT);

   // ---------------- score ----------------
`ifdef INVADER_SCORE_EN
   logic [15:0] score_q;
   logic [16:0] score_sum;

   assign score_sum = {1'b0, score_q} + {1'b0, row_points(int'(hit_idx) / COLS)};

   always_ff @(posedge clk) begin
      if (rst)
         score_q <= '0;
      else if (state == ST_HIT)
         score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   assign score = score_q;
`else
   assign score = '0;
`endif
endmodule
